// File: rtl/vector_wb_buffer_if.sv
// -----------------------------------------------------------------------------
// vector_wb_buffer_if
// Register-file write port between the vector writeback buffer (master) and the
// vector register file (slave). It carries one beat per accepted transfer.
//   rf_valid_o  master->slave  head entry valid
//   rf_ready_i  slave->master  register file accepts the head this cycle
//   rf_en_o     master->slave  head lane enables
//   rf_addr_o   master->slave  head destination vector register
//   rf_data_o   master->slave  head lane data, lane k at [k*DATA_WIDTH +: DATA_WIDTH]
// -----------------------------------------------------------------------------
interface vector_wb_buffer_if #(
    parameter int VECTOR_LANES = 8,
    parameter int DATA_WIDTH   = 32,
    parameter int ADDR_W       = 5
);
    logic                               rf_valid_o;
    logic                               rf_ready_i;
    logic [VECTOR_LANES-1:0]            rf_en_o;
    logic [ADDR_W-1:0]                  rf_addr_o;
    logic [VECTOR_LANES*DATA_WIDTH-1:0] rf_data_o;

    modport master (
        output rf_valid_o,
        input  rf_ready_i,
        output rf_en_o,
        output rf_addr_o,
        output rf_data_o
    );

    modport slave (
        input  rf_valid_o,
        output rf_ready_i,
        input  rf_en_o,
        input  rf_addr_o,
        input  rf_data_o
    );
endinterface

// File: rtl/vector_wb_buffer.sv
// -----------------------------------------------------------------------------
// vector_wb_buffer
// In-order writeback FIFO between the vector execution stage (no backpressure)
// and the vector register-file write port. Each accepted beat later produces a
// one-cycle retire pulse that carries the beat's ticket.
// Optional feature macro: VECTOR_WB_FWD_EN. When it is defined, the buffer
// runs a youngest-match forwarding lookup over the buffered entries. When it
// is undefined, the forwarding outputs are tied to zero.
// Ports:
//   clk, rst_n          clock, asynchronous active-low reset
//   wr_en_i/addr/data/ticket_i  writeback beat (present when any enable set)
//   rf                  register-file write port (vector_wb_buffer_if.master)
//   retire_valid_o/ticket_o     one-cycle pulse per beat written
//   stall_o             issue throttle (free entries < STALL_THRESHOLD)
//   count_o             occupied entries
//   overflow_o          sticky flag: a beat was dropped
//   idle_o              FIFO empty and no retire pending
//   fwd_addr_i/fwd_en_o/fwd_data_o  forwarding lookup
// -----------------------------------------------------------------------------
module vector_wb_buffer #(
    parameter int VECTOR_REGISTERS   = 32,
    parameter int VECTOR_LANES       = 8,
    parameter int DATA_WIDTH         = 32,
    parameter int VECTOR_TICKET_BITS = 5,
    parameter int DEPTH              = 8,
    parameter int STALL_THRESHOLD    = 4,
    localparam int ADDR_W = $clog2(VECTOR_REGISTERS),
    localparam int PTR_W  = $clog2(DEPTH),
    localparam int CNT_W  = $clog2(DEPTH) + 1
) (
    input  logic                               clk,
    input  logic                               rst_n,
    input  logic [VECTOR_LANES-1:0]            wr_en_i,
    input  logic [ADDR_W-1:0]                  wr_addr_i,
    input  logic [VECTOR_LANES*DATA_WIDTH-1:0] wr_data_i,
    input  logic [VECTOR_TICKET_BITS-1:0]      wr_ticket_i,
    vector_wb_buffer_if.master                 rf,
    output logic                               retire_valid_o,
    output logic [VECTOR_TICKET_BITS-1:0]      retire_ticket_o,
    output logic                               stall_o,
    output logic [CNT_W-1:0]                   count_o,
    output logic                               overflow_o,
    output logic                               idle_o,
    input  logic [ADDR_W-1:0]                  fwd_addr_i,
    output logic [VECTOR_LANES-1:0]            fwd_en_o,
    output logic [VECTOR_LANES*DATA_WIDTH-1:0] fwd_data_o
);
    localparam logic [CNT_W-1:0] FULL_COUNT   = CNT_W'(DEPTH);
    localparam logic [CNT_W-1:0] THRESH_COUNT = CNT_W'(STALL_THRESHOLD);

    // Payload storage is deliberately left out of reset.
    logic [VECTOR_LANES-1:0]            en_mem_r     [DEPTH];
    logic [ADDR_W-1:0]                  addr_mem_r   [DEPTH];
    logic [VECTOR_LANES*DATA_WIDTH-1:0] data_mem_r   [DEPTH];
    logic [VECTOR_TICKET_BITS-1:0]      ticket_mem_r [DEPTH];

    logic [PTR_W-1:0]              wr_ptr_r;
    logic [PTR_W-1:0]              rd_ptr_r;
    logic [CNT_W-1:0]              count_r;
    logic                          retire_valid_r;
    logic [VECTOR_TICKET_BITS-1:0] retire_ticket_r;
    logic                          overflow_r;
    logic                          stall_r;

    logic             push_s;
    logic             pop_s;
    logic             empty_s;
    logic             accept_s;
    logic [CNT_W-1:0] count_next_s;
    logic             stall_next_s;

    assign push_s  = |wr_en_i;
    assign empty_s = (count_r == {CNT_W{1'b0}});
    assign pop_s   = ~empty_s & rf.rf_ready_i;
    // When the FIFO is full, a push is accepted only if the head leaves on the same edge.
    assign accept_s = push_s & ((count_r != FULL_COUNT) | pop_s);

    // Next occupancy and the stall hint derived from it.
    always_comb begin
        count_next_s = count_r;
        if (accept_s & ~pop_s) begin
            count_next_s = count_r + CNT_W'(1);
        end else if (pop_s & ~accept_s) begin
            count_next_s = count_r - CNT_W'(1);
        end else begin
            count_next_s = count_r;
        end
        stall_next_s = ((FULL_COUNT - count_next_s) < THRESH_COUNT);
    end

    // Control state: pointers, occupancy, retire pulse, sticky overflow, stall.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_r        <= {PTR_W{1'b0}};
            rd_ptr_r        <= {PTR_W{1'b0}};
            count_r         <= {CNT_W{1'b0}};
            retire_valid_r  <= 1'b0;
            retire_ticket_r <= {VECTOR_TICKET_BITS{1'b0}};
            overflow_r      <= 1'b0;
            stall_r         <= 1'b0;
        end else begin
            if (accept_s) wr_ptr_r <= wr_ptr_r + PTR_W'(1);
            if (pop_s) begin
                rd_ptr_r        <= rd_ptr_r + PTR_W'(1);
                retire_ticket_r <= ticket_mem_r[rd_ptr_r];
            end
            if (push_s & ~accept_s) overflow_r <= 1'b1;
            count_r        <= count_next_s;
            stall_r        <= stall_next_s;
            retire_valid_r <= pop_s;
        end
    end

    // Payload write at the write pointer for each accepted beat.
    always_ff @(posedge clk) begin
        if (accept_s) begin
            en_mem_r[wr_ptr_r]     <= wr_en_i;
            addr_mem_r[wr_ptr_r]   <= wr_addr_i;
            data_mem_r[wr_ptr_r]   <= wr_data_i;
            ticket_mem_r[wr_ptr_r] <= wr_ticket_i;
        end
    end

    // Head entry presented to the register file; the outputs are zero when the FIFO is empty.
    always_comb begin
        rf.rf_valid_o = ~empty_s;
        if (empty_s) begin
            rf.rf_en_o   = {VECTOR_LANES{1'b0}};
            rf.rf_addr_o = {ADDR_W{1'b0}};
            rf.rf_data_o = {(VECTOR_LANES*DATA_WIDTH){1'b0}};
        end else begin
            rf.rf_en_o   = en_mem_r[rd_ptr_r];
            rf.rf_addr_o = addr_mem_r[rd_ptr_r];
            rf.rf_data_o = data_mem_r[rd_ptr_r];
        end
    end

    assign retire_valid_o  = retire_valid_r;
    assign retire_ticket_o = retire_ticket_r;
    assign stall_o         = stall_r;
    assign count_o         = count_r;
    assign overflow_o      = overflow_r;
    assign idle_o          = empty_s & ~retire_valid_r;

`ifdef VECTOR_WB_FWD_EN
    // The scan runs from oldest to youngest, so the last match (the youngest) wins.
    // The head that is being popped this cycle still takes part in the lookup.
    always_comb begin
        fwd_en_o   = {VECTOR_LANES{1'b0}};
        fwd_data_o = {(VECTOR_LANES*DATA_WIDTH){1'b0}};
        for (int i = 0; i < DEPTH; i++) begin
            if ((i < int'(count_r)) &&
                (addr_mem_r[rd_ptr_r + PTR_W'(i)] == fwd_addr_i)) begin
                fwd_en_o   = en_mem_r[rd_ptr_r + PTR_W'(i)];
                fwd_data_o = data_mem_r[rd_ptr_r + PTR_W'(i)];
            end else begin
                fwd_en_o   = fwd_en_o;
                fwd_data_o = fwd_data_o;
            end
        end
    end
`else
    logic unused_fwd_s;
    assign unused_fwd_s = ^fwd_addr_i;
    assign fwd_en_o     = {VECTOR_LANES{1'b0}};
    assign fwd_data_o   = {(VECTOR_LANES*DATA_WIDTH){1'b0}};
`endif

endmodule

// File: tb/tb_vector_wb_buffer.sv
// -----------------------------------------------------------------------------
// tb_vector_wb_buffer
// Self-checking bench for vector_wb_buffer. A queue of beats serves as the
// reference model. Each task drives one scenario and compares the DUT outputs
// against that queue model.
// -----------------------------------------------------------------------------
module tb_vector_wb_buffer;
    localparam int DEPTH = 8;
    localparam int THR   = 4;

    typedef struct {
        logic [7:0]   en;
        logic [4:0]   addr;
        logic [255:0] data;
        logic [4:0]   ticket;
    } beat_t;

    logic         clk;
    logic         rst_n;
    logic [7:0]   wr_en;
    logic [4:0]   wr_addr;
    logic [255:0] wr_data;
    logic [4:0]   wr_ticket;
    logic         retire_valid;
    logic [4:0]   retire_ticket;
    logic         stall;
    logic [3:0]   count;
    logic         overflow;
    logic         idle;
    logic [4:0]   fwd_addr;
    logic [7:0]   fwd_en;
    logic [255:0] fwd_data;

    int n_checks = 0;
    int n_fail   = 0;

    beat_t mq[$];
    logic       exp_ret_v = 1'b0;
    logic [4:0] exp_ret_t = 5'd0;
    logic       exp_ovf   = 1'b0;

    vector_wb_buffer_if #(.VECTOR_LANES(8), .DATA_WIDTH(32), .ADDR_W(5)) rf_bus ();

    vector_wb_buffer dut (
        .clk             (clk),
        .rst_n           (rst_n),
        .wr_en_i         (wr_en),
        .wr_addr_i       (wr_addr),
        .wr_data_i       (wr_data),
        .wr_ticket_i     (wr_ticket),
        .rf              (rf_bus),
        .retire_valid_o  (retire_valid),
        .retire_ticket_o (retire_ticket),
        .stall_o         (stall),
        .count_o         (count),
        .overflow_o      (overflow),
        .idle_o          (idle),
        .fwd_addr_i      (fwd_addr),
        .fwd_en_o        (fwd_en),
        .fwd_data_o      (fwd_data)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [255:0] rand_data();
        logic [255:0] d;
        for (int k = 0; k < 8; k++) d[k*32 +: 32] = $urandom;
        return d;
    endfunction

    function automatic logic [3:0] exp_count();
        return 4'(mq.size());
    endfunction

    function automatic logic exp_stall();
        return (DEPTH - mq.size()) < THR;
    endfunction

    function automatic logic exp_idle();
        return (mq.size() == 0) && !exp_ret_v;
    endfunction

    function automatic logic [255:0] exp_head_data();
        if (mq.size() == 0) return 256'd0;
        return mq[0].data;
    endfunction

    function automatic logic [7:0] exp_fwd_en();
        logic [7:0] r;
        r = 8'h00;
`ifdef VECTOR_WB_FWD_EN
        for (int k = mq.size() - 1; k >= 0; k--) begin
            if (mq[k].addr == fwd_addr) begin
                r = mq[k].en;
                break;
            end
        end
`endif
        return r;
    endfunction

    function automatic logic [255:0] exp_fwd_data();
        logic [255:0] r;
        r = 256'd0;
`ifdef VECTOR_WB_FWD_EN
        for (int k = mq.size() - 1; k >= 0; k--) begin
            if (mq[k].addr == fwd_addr) begin
                r = mq[k].data;
                break;
            end
        end
`endif
        return r;
    endfunction

    // Advances the reference model by one clock edge and then waits for the DUT edge.
    task automatic step();
        beat_t b;
        logic  pop;
        pop = (mq.size() != 0) && (rf_bus.rf_ready_i === 1'b1);
        exp_ret_v = pop;
        if (pop) begin
            exp_ret_t = mq[0].ticket;
            void'(mq.pop_front());
        end
        if (wr_en != 8'h00) begin
            if (mq.size() < DEPTH) begin
                b.en = wr_en; b.addr = wr_addr; b.data = wr_data; b.ticket = wr_ticket;
                mq.push_back(b);
            end else begin
                exp_ovf = 1'b1;
            end
        end
        @(posedge clk);
        #1;
    endtask

    task automatic set_beat(input logic [7:0] en, input logic [4:0] addr, input logic [4:0] tkt);
        wr_en = en; wr_addr = addr; wr_ticket = tkt; wr_data = rand_data();
    endtask

    task automatic idle_inputs();
        wr_en = 8'h00; wr_addr = 5'd0; wr_ticket = 5'd0; wr_data = 256'd0;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        idle_inputs();
        fwd_addr = 5'd0;
        rf_bus.rf_ready_i = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        n_checks++; if (count !== 4'd0) begin n_fail++; $display("FAIL reset_count actual=%0d expected=0", count); end
        n_checks++; if (rf_bus.rf_valid_o !== 1'b0) begin n_fail++; $display("FAIL reset_rf_valid actual=%b expected=0", rf_bus.rf_valid_o); end
        n_checks++; if (retire_valid !== 1'b0) begin n_fail++; $display("FAIL reset_retire actual=%b expected=0", retire_valid); end
        n_checks++; if ({stall, overflow, idle} !== 3'b001) begin n_fail++; $display("FAIL reset_flags actual=%b expected=001", {stall, overflow, idle}); end
        n_checks++; if ((fwd_en !== 8'h00) || (fwd_data !== 256'd0)) begin n_fail++; $display("FAIL reset_fwd actual=%h expected=0", fwd_en); end
        rst_n = 1'b1;
        #2;
    endtask

    task automatic test_single_beat();
        rf_bus.rf_ready_i = 1'b1;
        set_beat(8'hFF, 5'd5, 5'd3);
        step();
        idle_inputs();
        n_checks++; if (rf_bus.rf_valid_o !== 1'b1) begin n_fail++; $display("FAIL single_valid actual=%b expected=1", rf_bus.rf_valid_o); end
        n_checks++; if (rf_bus.rf_addr_o !== 5'd5) begin n_fail++; $display("FAIL single_addr actual=%0d expected=5", rf_bus.rf_addr_o); end
        n_checks++; if (rf_bus.rf_data_o !== exp_head_data()) begin n_fail++; $display("FAIL single_data actual=%h expected=%h", rf_bus.rf_data_o, exp_head_data()); end
        step();
        n_checks++; if ((retire_valid !== 1'b1) || (retire_ticket !== 5'd3)) begin n_fail++; $display("FAIL single_retire actual=%b/%0d expected=1/3", retire_valid, retire_ticket); end
        step();
        n_checks++; if ((idle !== 1'b1) || (retire_valid !== 1'b0)) begin n_fail++; $display("FAIL single_idle actual=%b/%b expected=1/0", idle, retire_valid); end
    endtask

    task automatic test_backpressure();
        int   retired;
        logic [4:0] head_addr;
        rf_bus.rf_ready_i = 1'b0;
        head_addr = 5'($urandom_range(0, 31));
        for (int i = 0; i < 6; i++) begin
            set_beat(8'($urandom_range(1, 255)), (i == 0) ? head_addr : 5'($urandom_range(0, 31)), 5'(10 + i));
            step();
            n_checks++; if ((count !== exp_count()) || (stall !== exp_stall())) begin n_fail++; $display("FAIL bp_count_stall beat=%0d actual=%0d/%b expected=%0d/%b", i, count, stall, exp_count(), exp_stall()); end
            if (i == 4) begin
                n_checks++; if (stall !== 1'b1) begin n_fail++; $display("FAIL bp_stall_5th actual=%b expected=1", stall); end
            end
        end
        idle_inputs();
        n_checks++; if ((count !== 4'd6) || (rf_bus.rf_addr_o !== head_addr) || (rf_bus.rf_data_o !== exp_head_data())) begin n_fail++; $display("FAIL bp_head actual=%0d/%0d expected=6/%0d", count, rf_bus.rf_addr_o, head_addr); end
        rf_bus.rf_ready_i = 1'b1;
        retired = 0;
        for (int c = 0; c < 10; c++) begin
            step();
            if (exp_ret_v) retired++;
            n_checks++; if ((retire_valid !== exp_ret_v) || (exp_ret_v && (retire_ticket !== exp_ret_t))) begin n_fail++; $display("FAIL bp_retire cycle=%0d actual=%b/%0d expected=%b/%0d", c, retire_valid, retire_ticket, exp_ret_v, exp_ret_t); end
        end
        n_checks++; if ((retired != 6) || (idle !== 1'b1)) begin n_fail++; $display("FAIL bp_drain actual=%0d/%b expected=6/1", retired, idle); end
    endtask

    task automatic test_full_pop();
        rf_bus.rf_ready_i = 1'b0;
        for (int i = 0; i < DEPTH; i++) begin
            set_beat(8'($urandom_range(1, 255)), 5'($urandom_range(0, 31)), 5'(i));
            step();
        end
        n_checks++; if ((count !== 4'd8) || (stall !== 1'b1)) begin n_fail++; $display("FAIL full_fill actual=%0d/%b expected=8/1", count, stall); end
        rf_bus.rf_ready_i = 1'b1;
        set_beat(8'h01, 5'd9, 5'd20);
        step();
        idle_inputs();
        n_checks++; if ((count !== 4'd8) || (overflow !== 1'b0) || (count !== exp_count())) begin n_fail++; $display("FAIL full_pop_push actual=%0d/%b expected=8/0", count, overflow); end
        n_checks++; if ((retire_valid !== 1'b1) || (retire_ticket !== 5'd0)) begin n_fail++; $display("FAIL full_pop_retire actual=%b/%0d expected=1/0", retire_valid, retire_ticket); end
        for (int c = 0; c < 10; c++) begin
            step();
            n_checks++; if ((retire_valid !== exp_ret_v) || (exp_ret_v && (retire_ticket !== exp_ret_t))) begin n_fail++; $display("FAIL full_drain cycle=%0d actual=%b/%0d expected=%b/%0d", c, retire_valid, retire_ticket, exp_ret_v, exp_ret_t); end
        end
    endtask

    task automatic test_wrap();
        int pushed;
        int retired;
        int cyc;
        pushed = 0; retired = 0; cyc = 0;
        while (((pushed < 20) || (mq.size() != 0) || exp_ret_v) && (cyc < 300)) begin
            rf_bus.rf_ready_i = ($urandom_range(0, 99) < 60);
            if ((pushed < 20) && (mq.size() < DEPTH) && ($urandom_range(0, 99) < 70)) begin
                set_beat(8'($urandom_range(1, 255)), 5'($urandom_range(0, 31)), 5'(pushed));
                pushed++;
            end else begin
                idle_inputs();
            end
            step();
            cyc++;
            if (exp_ret_v) retired++;
            n_checks++; if ((retire_valid !== exp_ret_v) || (exp_ret_v && (retire_ticket !== exp_ret_t))) begin n_fail++; $display("FAIL wrap_retire cycle=%0d actual=%b/%0d expected=%b/%0d", cyc, retire_valid, retire_ticket, exp_ret_v, exp_ret_t); end
            n_checks++; if ((count !== exp_count()) || (rf_bus.rf_data_o !== exp_head_data()) || (stall !== exp_stall())) begin n_fail++; $display("FAIL wrap_head cycle=%0d actual=%0d expected=%0d", cyc, count, exp_count()); end
        end
        idle_inputs();
        n_checks++; if ((retired != 20) || (cyc >= 300) || (overflow !== 1'b0)) begin n_fail++; $display("FAIL wrap_total actual=%0d expected=20 (cycles=%0d)", retired, cyc); end
    endtask

    task automatic test_forward();
        rf_bus.rf_ready_i = 1'b0;
        set_beat(8'h0F, 5'd7, 5'd1); step();
        set_beat(8'hF0, 5'd7, 5'd2); step();
        set_beat(8'h33, 5'd3, 5'd4); step();
        idle_inputs();
        fwd_addr = 5'd7;
        #1;
`ifdef VECTOR_WB_FWD_EN
        n_checks++; if (fwd_en !== 8'hF0) begin n_fail++; $display("FAIL fwd_youngest actual=%h expected=f0", fwd_en); end
`else
        n_checks++; if (fwd_en !== 8'h00) begin n_fail++; $display("FAIL fwd_disabled actual=%h expected=00", fwd_en); end
`endif
        n_checks++; if ((fwd_en !== exp_fwd_en()) || (fwd_data !== exp_fwd_data())) begin n_fail++; $display("FAIL fwd_addr7 actual=%h expected=%h", fwd_en, exp_fwd_en()); end
        fwd_addr = 5'd3;
        #1;
        n_checks++; if ((fwd_en !== exp_fwd_en()) || (fwd_data !== exp_fwd_data())) begin n_fail++; $display("FAIL fwd_addr3 actual=%h expected=%h", fwd_en, exp_fwd_en()); end
        fwd_addr = 5'd9;
        #1;
        n_checks++; if ((fwd_en !== 8'h00) || (fwd_data !== 256'd0)) begin n_fail++; $display("FAIL fwd_nomatch actual=%h expected=00", fwd_en); end
        rf_bus.rf_ready_i = 1'b1;
        repeat (5) step();
        n_checks++; if ((idle !== 1'b1) || (fwd_en !== 8'h00)) begin n_fail++; $display("FAIL fwd_empty actual=%b/%h expected=1/00", idle, fwd_en); end
    endtask

    task automatic test_overflow();
        int retired;
        rf_bus.rf_ready_i = 1'b0;
        for (int i = 0; i < DEPTH + 1; i++) begin
            set_beat(8'($urandom_range(1, 255)), 5'($urandom_range(0, 31)), 5'(i));
            step();
        end
        idle_inputs();
        n_checks++; if ((overflow !== 1'b1) || (count !== 4'd8) || (overflow !== exp_ovf)) begin n_fail++; $display("FAIL ovf_set actual=%b/%0d expected=1/8", overflow, count); end
        rf_bus.rf_ready_i = 1'b1;
        retired = 0;
        for (int c = 0; c < 12; c++) begin
            step();
            if (retire_valid === 1'b1) retired++;
            n_checks++; if ((retire_valid !== exp_ret_v) || (exp_ret_v && (retire_ticket !== exp_ret_t))) begin n_fail++; $display("FAIL ovf_drain cycle=%0d actual=%b/%0d expected=%b/%0d", c, retire_valid, retire_ticket, exp_ret_v, exp_ret_t); end
        end
        n_checks++; if ((retired != 8) || (overflow !== 1'b1)) begin n_fail++; $display("FAIL ovf_sticky actual=%0d/%b expected=8/1", retired, overflow); end
    endtask

    task automatic test_reset_mid();
        rf_bus.rf_ready_i = 1'b0;
        fwd_addr = 5'd6;
        for (int i = 0; i < 3; i++) begin
            set_beat(8'hFF, 5'd6, 5'(i));
            step();
        end
        rf_bus.rf_ready_i = 1'b1;
        step();
        idle_inputs();
        rst_n = 1'b0;
        #1;
        mq.delete();
        exp_ret_v = 1'b0;
        exp_ovf   = 1'b0;
        n_checks++; if ((count !== 4'd0) || (rf_bus.rf_valid_o !== 1'b0) || (retire_valid !== 1'b0)) begin n_fail++; $display("FAIL rstmid_state actual=%0d/%b/%b expected=0/0/0", count, rf_bus.rf_valid_o, retire_valid); end
        n_checks++; if ({stall, overflow, idle} !== 3'b001) begin n_fail++; $display("FAIL rstmid_flags actual=%b expected=001", {stall, overflow, idle}); end
        n_checks++; if ((fwd_en !== 8'h00) || (fwd_data !== 256'd0)) begin n_fail++; $display("FAIL rstmid_fwd actual=%h expected=00", fwd_en); end
        #3;
        rst_n = 1'b1;
        for (int c = 0; c < 3; c++) begin
            step();
            n_checks++; if ((retire_valid !== 1'b0) || (idle !== 1'b1)) begin n_fail++; $display("FAIL rstmid_noretire cycle=%0d actual=%b/%b expected=0/1", c, retire_valid, idle); end
        end
    endtask

    initial begin
        test_reset();
        test_single_beat();
        test_backpressure();
        test_full_pop();
        test_wrap();
        test_forward();
        test_overflow();
        test_reset_mid();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
